// File: rtl/bridge_pkg.sv
// bridge_pkg: shared definitions for the sys_bridge_n CPU-to-device bridge.
// Holds the transfer FSM state encoding, the default device address map and
// the width of the CPU hardware interrupt vector.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bridge_state_e;

    // Default byte address map (inclusive limits)
    localparam logic [31:0] DEV0_BASE  = 32'h7A00;
    localparam logic [31:0] DEV0_LIMIT = 32'h7A03;
    localparam logic [31:0] DEV1_BASE  = 32'h7B00;
    localparam logic [31:0] DEV1_LIMIT = 32'h7B0B;
    localparam logic [31:0] DEV2_BASE  = 32'h7F00;
    localparam logic [31:0] DEV2_LIMIT = 32'h7F0B;

    localparam int unsigned HWINT_W = 6;

endpackage

// File: rtl/bridge_irq_sync.sv
// bridge_irq_sync: two-flop synchroniser for asynchronous interrupt levels.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset, clears both stages
//   async_i - WIDTH asynchronous input levels
//   sync_o  - WIDTH levels synchronised to clk (two-edge latency)
module bridge_irq_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sys_bridge_n.sv
// sys_bridge_n: single-master bridge from a simple CPU request port to NDEV
// address-mapped devices, plus a synchronised interrupt vector.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   pr_req/we/addr/wd   - CPU request (word address), sampled in IDLE only
//   pr_ack/rd/err       - one-cycle completion pulse with read data / error
//   dev_sel/dev_we      - one-hot device select and write strobe
//   dev_addr/dev_wd     - word offset into the device and write data
//   dev_rd/dev_ready    - packed device read data and per-device completion
//   irq_in/hwint        - asynchronous device interrupts -> CPU vector
module sys_bridge_n
    import bridge_pkg::*;
#(
    parameter int unsigned NDEV = 3,
    parameter logic [NDEV*32-1:0] DEV_BASE  = {DEV2_BASE,  DEV1_BASE,  DEV0_BASE},
    parameter logic [NDEV*32-1:0] DEV_LIMIT = {DEV2_LIMIT, DEV1_LIMIT, DEV0_LIMIT},
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pr_req,
    input  logic                 pr_we,
    input  logic [29:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    output logic                 pr_ack,
    output logic [31:0]          pr_rd,
    output logic                 pr_err,
    output logic [NDEV-1:0]      dev_sel,
    output logic [NDEV-1:0]      dev_we,
    output logic [3:0]           dev_addr,
    output logic [31:0]          dev_wd,
    input  logic [NDEV*32-1:0]   dev_rd,
    input  logic [NDEV-1:0]      dev_ready,
    input  logic [NDEV-1:0]      irq_in,
    output logic [HWINT_W-1:0]   hwint
);

    localparam int unsigned IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    bridge_state_e    state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      wd_q, wd_d;
    logic [3:0]       off_q, off_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic [NDEV-1:0]  sel_q, sel_d;
    logic [NDEV-1:0]  dwe_q, dwe_d;

    logic [31:0]      req_baddr;
    logic             dec_hit;
    logic [IDXW-1:0]  dec_idx;
    logic [31:0]      dec_diff;

    assign req_baddr = {pr_addr, 2'b00};

    // Address decode; the first matching index is kept so lower indices win
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_diff = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (!dec_hit &&
                req_baddr >= DEV_BASE[i*32 +: 32] &&
                req_baddr <= DEV_LIMIT[i*32 +: 32]) begin
                dec_hit  = 1'b1;
                dec_idx  = IDXW'(i);
                dec_diff = req_baddr - DEV_BASE[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        wd_d    = wd_q;
        off_d   = off_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        sel_d   = sel_q;
        dwe_d   = dwe_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pr_req) begin
                    if (dec_hit) begin
                        we_d          = pr_we;
                        wd_d          = pr_wd;
                        off_d         = dec_diff[5:2];
                        idx_d         = dec_idx;
                        cnt_d         = '0;
                        sel_d         = '0;
                        sel_d[dec_idx] = 1'b1;
                        dwe_d         = '0;
                        dwe_d[dec_idx] = pr_we;
                        state_d       = ST_ACCESS;
                    end else begin
                        rd_d    = '0;
                        err_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked before the timeout so a ready in the last
                // allowed cycle still completes without error
                if (dev_ready[idx_q]) begin
                    rd_d    = we_q ? 32'h0 : dev_rd[idx_q*32 +: 32];
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    sel_d   = '0;
                    dwe_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    sel_d   = '0;
                    dwe_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            wd_q    <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            sel_q   <= '0;
            dwe_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            dwe_q   <= dwe_d;
        end
    end

    assign pr_ack   = ack_q;
    assign pr_rd    = rd_q;
    assign pr_err   = err_q;
    assign dev_sel  = sel_q;
    assign dev_we   = dwe_q;
    assign dev_addr = off_q;
    assign dev_wd   = wd_q;

    logic [NDEV-1:0] irq_sync;

    bridge_irq_sync #(
        .WIDTH(NDEV)
    ) u_irq_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(irq_in),
        .sync_o (irq_sync)
    );

    for (genvar g = 0; g < HWINT_W; g++) begin : g_hwint
        if (g < NDEV) begin : g_map
            assign hwint[g] = irq_sync[g];
        end else begin : g_zero
            assign hwint[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_sys_bridge_n.sv
module tb_sys_bridge_n;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pr_req, pr_we;
    logic [29:0]  pr_addr;
    logic [31:0]  pr_wd;
    logic         pr_ack, pr_err;
    logic [31:0]  pr_rd;
    logic [2:0]   dev_sel, dev_we;
    logic [3:0]   dev_addr;
    logic [31:0]  dev_wd;
    logic [95:0]  dev_rd;
    logic [2:0]   dev_ready;
    logic [2:0]   irq_in;
    logic [5:0]   hwint;

    // NDEV=8 instance, used only for the interrupt vector mapping
    logic         a8_ack, a8_err;
    logic [31:0]  a8_rd, a8_wd;
    logic [7:0]   a8_sel, a8_we;
    logic [3:0]   a8_addr;
    logic [7:0]   irq8;
    logic [5:0]   hwint8;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;

    logic [32:0]  exp_q[$];   // {rd, err}

    always #5 clk = ~clk;

    sys_bridge_n #(
        .NDEV(3),
        .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr), .pr_wd(pr_wd),
        .pr_ack(pr_ack), .pr_rd(pr_rd), .pr_err(pr_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
        .dev_rd(dev_rd), .dev_ready(dev_ready),
        .irq_in(irq_in), .hwint(hwint)
    );

    sys_bridge_n #(
        .NDEV(8),
        .DEV_BASE('0),
        .DEV_LIMIT('0),
        .TIMEOUT(15)
    ) dut8 (
        .clk(clk), .rst_n(rst_n),
        .pr_req(1'b0), .pr_we(1'b0), .pr_addr(30'h0), .pr_wd(32'h0),
        .pr_ack(a8_ack), .pr_rd(a8_rd), .pr_err(a8_err),
        .dev_sel(a8_sel), .dev_we(a8_we), .dev_addr(a8_addr), .dev_wd(a8_wd),
        .dev_rd(256'h0), .dev_ready(8'h0),
        .irq_in(irq8), .hwint(hwint8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (pr_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("pr_rd", pr_rd, e[32:1]);
                check("pr_err", {31'h0, pr_err}, {31'h0, e[0]});
            end
        end
    end

    // rdy: ACCESS cycle (1-based) in which the target raises ready, 0 = never
    // noise: ready bits raised on other devices in ACCESS cycle 1
    task automatic run_txn(input logic we, input logic [31:0] baddr, input logic [31:0] wd,
                           input logic [2:0] mask, input int rdy, input logic [2:0] noise,
                           input logic [3:0] exp_off, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat);
        int lat;
        lat = -1;
        exp_q.push_back({exp_rd, exp_err});
        @(negedge clk);
        pr_req  = 1'b1;
        pr_we   = we;
        pr_addr = baddr[31:2];
        pr_wd   = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (pr_ack) begin
                lat = c;
                check("sel_in_resp", {29'h0, dev_sel}, 32'h0);
                pr_req    = 1'b0;
                dev_ready = '0;
                break;
            end
            check("dev_sel", {29'h0, dev_sel}, {29'h0, mask});
            check("dev_we", {29'h0, dev_we}, we ? {29'h0, mask} : 32'h0);
            if (c == 1) begin
                check("dev_addr", {28'h0, dev_addr}, {28'h0, exp_off});
                check("dev_wd", dev_wd, wd);
            end
            dev_ready = (c == rdy) ? mask : ((c == 1) ? noise : 3'b000);
        end
        if (lat < 0) begin
            check("ack_timeout", 32'd0, 32'd1);
            pr_req    = 1'b0;
            dev_ready = '0;
        end else begin
            check("ack_latency", lat, exp_lat);
            @(negedge clk);
            check("ack_pulse", {31'h0, pr_ack}, 32'h0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        pr_req    = 1'b0;
        pr_we     = 1'b0;
        pr_addr   = '0;
        pr_wd     = '0;
        dev_ready = '0;
        dev_rd    = {32'h0BAD0002, 32'hCAFE0001, 32'h0BAD0000};
        irq_in    = '0;
        irq8      = '0;

        repeat (2) @(negedge clk);
        check("rst_ack", {31'h0, pr_ack}, 32'h0);
        check("rst_rd", pr_rd, 32'h0);
        check("rst_err", {31'h0, pr_err}, 32'h0);
        check("rst_sel", {29'h0, dev_sel}, 32'h0);
        check("rst_addr", {28'h0, dev_addr}, 32'h0);
        check("rst_wd", dev_wd, 32'h0);
        check("rst_hwint", {26'h0, hwint}, 32'h0);
        rst_n = 1'b1;

        //       we    addr          wd          mask    rdy noise   off    exp_rd         err lat
        run_txn(1'b0, 32'h7B04, 32'h0,       3'b010, 3,  3'b000, 4'd1, 32'hCAFE0001, 1'b0, 4);
        run_txn(1'b1, 32'h7A00, 32'h55,      3'b001, 4,  3'b000, 4'd0, 32'h0,        1'b0, 5);
        run_txn(1'b0, 32'h1000, 32'h0,       3'b000, 0,  3'b000, 4'd0, 32'h0,        1'b1, 1);
        run_txn(1'b0, 32'h7B04, 32'h0,       3'b010, 1,  3'b000, 4'd1, 32'hCAFE0001, 1'b0, 2);
        run_txn(1'b0, 32'h7F08, 32'h0,       3'b100, 0,  3'b000, 4'd2, 32'h0,        1'b1, 16);
        run_txn(1'b0, 32'h7F08, 32'h0,       3'b100, 15, 3'b000, 4'd2, 32'h0BAD0002, 1'b0, 16);
        run_txn(1'b0, 32'h7F08, 32'h0,       3'b100, 2,  3'b011, 4'd2, 32'h0BAD0002, 1'b0, 3);
        run_txn(1'b1, 32'h7B08, 32'hA5A5,    3'b010, 1,  3'b000, 4'd2, 32'h0,        1'b0, 2);
        run_txn(1'b0, 32'h7A00, 32'h0,       3'b001, 1,  3'b000, 4'd0, 32'h0BAD0000, 1'b0, 2);
        run_txn(1'b0, 32'h7B0C, 32'h0,       3'b000, 0,  3'b000, 4'd0, 32'h0,        1'b1, 1);
        run_txn(1'b0, 32'h79FC, 32'h0,       3'b000, 0,  3'b000, 4'd0, 32'h0,        1'b1, 1);

        // Reset in the middle of an access aborts it with no response
        @(negedge clk);
        pr_req  = 1'b1;
        pr_we   = 1'b1;
        pr_addr = 30'(32'h7B04 >> 2);
        pr_wd   = 32'h1234;
        repeat (2) @(negedge clk);
        check("abort_sel_pre", {29'h0, dev_sel}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sel", {29'h0, dev_sel}, 32'h0);
        check("abort_we", {29'h0, dev_we}, 32'h0);
        check("abort_ack", {31'h0, pr_ack}, 32'h0);
        pr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_noack", {31'h0, pr_ack}, 32'h0);
        rst_n = 1'b1;
        run_txn(1'b0, 32'h7B04, 32'h0, 3'b010, 2, 3'b000, 4'd1, 32'hCAFE0001, 1'b0, 3);

        // Interrupt synchroniser: two-edge latency, upper NDEV bits hidden
        @(negedge clk);
        irq_in = 3'b100;
        irq8   = 8'b1100_0101;
        @(negedge clk);
        check("hwint_1edge", {26'h0, hwint}, 32'h0);
        @(negedge clk);
        check("hwint", {26'h0, hwint}, 32'h4);
        check("hwint8", {26'h0, hwint8}, 32'h05);
        irq8 = 8'hFF;
        repeat (2) @(negedge clk);
        check("hwint8_all", {26'h0, hwint8}, 32'h3F);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
